// File: rtl/sprite_bank_animator.sv
// sprite_bank_animator: multi-channel ghost sprite renderer with a shared two-frame
// bitmap, a frame-synchronous NORMAL/FRIGHT/BLINK mode machine and leg animation.
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   startOfFrame         one-cycle pulse per video frame
//   frightenStart        one-cycle request to enter FRIGHT
//   offsetX/offsetY      per-channel pixel offset from sprite top-left
//   insideRect           per-channel bracket hit
//   chColor              per-channel NORMAL body colour
//   RGBout               registered per-channel pixel colour
//   drawingRequest       RGBout != TRANSPARENT (decoded from the registered colour)
//   hitEdgeCode          registered per-channel {Left,Top,Right,Bottom}
//   mode, legFrame       animation state
module sprite_bank_animator #(
  parameter int unsigned NUM_CH        = 3,
  parameter int unsigned SIZE_BITS     = 5,
  parameter logic [7:0]  TRANSPARENT   = 8'h00,
  parameter logic [7:0]  FRIGHT_COLOR  = 8'h03,
  parameter logic [7:0]  BLINK_COLOR   = 8'hFF,
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned BLINK_FRAMES  = 120,
  parameter int unsigned BLINK_PERIOD  = 15,
  parameter int unsigned ANIM_FRAMES   = 8
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         frightenStart,
  input  logic [NUM_CH-1:0][10:0]      offsetX,
  input  logic [NUM_CH-1:0][10:0]      offsetY,
  input  logic [NUM_CH-1:0]            insideRect,
  input  logic [NUM_CH-1:0][7:0]       chColor,
  output logic [NUM_CH-1:0][7:0]       RGBout,
  output logic [NUM_CH-1:0]            drawingRequest,
  output logic [NUM_CH-1:0][3:0]       hitEdgeCode,
  output logic [1:0]                   mode,
  output logic                         legFrame
);

  localparam int unsigned FRAME_LIM = (FRIGHT_FRAMES > BLINK_FRAMES) ? FRIGHT_FRAMES : BLINK_FRAMES;
  localparam int unsigned FRAME_W   = (FRAME_LIM > 1)    ? $clog2(FRAME_LIM)    : 1;
  localparam int unsigned BLINK_W   = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int unsigned ANIM_W    = (ANIM_FRAMES > 1)  ? $clog2(ANIM_FRAMES)  : 1;
  // The bitmap is drawn on a 32x32 grid; other sprite sizes rescale onto it.
  localparam int unsigned GRID_DN   = (SIZE_BITS >= 5) ? SIZE_BITS - 5 : 0;
  localparam int unsigned GRID_UP   = (SIZE_BITS < 5)  ? 5 - SIZE_BITS : 0;

  localparam logic [7:0] PX_BODY  = 8'hFF;
  localparam logic [7:0] PX_WHITE = 8'hFE;
  localparam logic [7:0] PX_PUPIL = 8'h06;
  localparam logic [7:0] PX_NONE  = 8'h00;
  localparam logic [7:0] RED_PUPIL = 8'hC0;
  localparam logic [7:0] BODY_SUBST = 8'h01;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_FRIGHT = 2'b01,
    MODE_BLINK  = 2'b10
  } mode_e;

  mode_e                          state_q, state_d;
  logic [FRAME_W-1:0]             frame_cnt_q, frame_cnt_d;
  logic [BLINK_W-1:0]             blink_cnt_q, blink_cnt_d;
  logic                           blink_phase_q, blink_phase_d;
  logic [ANIM_W-1:0]              anim_cnt_q, anim_cnt_d;
  logic                           leg_q, leg_d;
  logic                           pend_q, pend_d;
  logic [NUM_CH-1:0][7:0]         rgb_q, rgb_d;
  logic [NUM_CH-1:0][3:0]         hit_q, hit_d;

  logic [7:0]                     mode_body_c;
  logic [7:0]                     mode_pupil_c;

  // Ghost bitmap on a 32x32 grid; frames differ only in rows 28..31 (legs).
  function automatic logic [7:0] ghost_px(input logic leg, input logic [4:0] x, input logic [4:0] y);
    logic body;
    logic [7:0] px;
    body = 1'b0;
    if (y < 5'd2)       body = (x >= 5'd10) && (x <= 5'd21);
    else if (y < 5'd4)  body = (x >= 5'd6)  && (x <= 5'd25);
    else if (y < 5'd6)  body = (x >= 5'd3)  && (x <= 5'd28);
    else if (y < 5'd28) body = (x >= 5'd1)  && (x <= 5'd30);
    else                body = (x >= 5'd1)  && (x <= 5'd30) && (x[2] == leg);
    px = body ? PX_BODY : PX_NONE;
    if (body && (y >= 5'd9) && (y <= 5'd15)) begin
      if (((x >= 5'd8) && (x <= 5'd14)) || ((x >= 5'd18) && (x <= 5'd24))) px = PX_WHITE;
      if ((y >= 5'd12) && (y <= 5'd14) &&
          (((x >= 5'd12) && (x <= 5'd14)) || ((x >= 5'd22) && (x <= 5'd24)))) px = PX_PUPIL;
    end
    return px;
  endfunction

  // Edge-hit code per 4x4 region grid cell.
  function automatic logic [3:0] hit_lut(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'hC;  4'h1: code = 4'h4;  4'h2: code = 4'h4;  4'h3: code = 4'h6;
      4'h4: code = 4'h8;  4'h5: code = 4'hC;  4'h6: code = 4'h6;  4'h7: code = 4'h2;
      4'h8: code = 4'h8;  4'h9: code = 4'h9;  4'hA: code = 4'h3;  4'hB: code = 4'h2;
      4'hC: code = 4'h9;  4'hD: code = 4'h1;  4'hE: code = 4'h1;  default: code = 4'h3;
    endcase
    return code;
  endfunction

  // Mode/animation state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= MODE_NORMAL;
      frame_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      anim_cnt_q    <= '0;
      leg_q         <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      anim_cnt_q    <= anim_cnt_d;
      leg_q         <= leg_d;
      pend_q        <= pend_d;
    end
  end

  // Next-state: everything but the pending latch moves only on startOfFrame.
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    anim_cnt_d    = anim_cnt_q;
    leg_d         = leg_q;
    pend_d        = pend_q | frightenStart;
    if (startOfFrame) begin
      if (anim_cnt_q == ANIM_W'(ANIM_FRAMES - 1)) begin
        anim_cnt_d = '0;
        leg_d      = ~leg_q;
      end else begin
        anim_cnt_d = anim_cnt_q + ANIM_W'(1);
      end
      // A request arriving on the SOF cycle itself is consumed immediately.
      if (pend_q || frightenStart) begin
        pend_d        = 1'b0;
        state_d       = MODE_FRIGHT;
        frame_cnt_d   = '0;
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
      end else begin
        case (state_q)
          MODE_FRIGHT: begin
            if (frame_cnt_q == FRAME_W'(FRIGHT_FRAMES - 1)) begin
              state_d     = MODE_BLINK;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
          end
          MODE_BLINK: begin
            if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
              state_d     = MODE_NORMAL;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
            if (blink_cnt_q == BLINK_W'(BLINK_PERIOD - 1)) begin
              blink_cnt_d   = '0;
              blink_phase_d = ~blink_phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
          end
          default: state_d = MODE_NORMAL;
        endcase
      end
    end
  end

  // Mode-dependent colour substitutions shared by all channels.
  always_comb begin
    mode_body_c  = FRIGHT_COLOR;
    mode_pupil_c = RED_PUPIL;
    case (state_q)
      MODE_NORMAL: mode_pupil_c = PX_PUPIL;
      MODE_BLINK:  mode_body_c  = blink_phase_q ? BLINK_COLOR : FRIGHT_COLOR;
      default:     mode_body_c  = FRIGHT_COLOR;
    endcase
  end

  // Per-channel pixel path: ROM lookup, colour map and hit code.
  always_comb begin
    rgb_d = '0;
    hit_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      logic [SIZE_BITS-1:0] ox;
      logic [SIZE_BITS-1:0] oy;
      logic [7:0]           code;
      logic [7:0]           body;
      ox       = offsetX[i][SIZE_BITS-1:0];
      oy       = offsetY[i][SIZE_BITS-1:0];
      code     = ghost_px(leg_q, 5'((32'(ox) >> GRID_DN) << GRID_UP),
                                 5'((32'(oy) >> GRID_DN) << GRID_UP));
      body     = mode_body_c;
      if (state_q == MODE_NORMAL) body = (chColor[i] == TRANSPARENT) ? BODY_SUBST : chColor[i];
      rgb_d[i] = TRANSPARENT;
      if (insideRect[i] && ((32'(offsetX[i]) >> SIZE_BITS) == 32'd0) &&
          ((32'(offsetY[i]) >> SIZE_BITS) == 32'd0)) begin
        hit_d[i] = hit_lut(oy[SIZE_BITS-1 -: 2], ox[SIZE_BITS-1 -: 2]);
        case (code)
          PX_BODY:  rgb_d[i] = body;
          PX_WHITE: rgb_d[i] = PX_WHITE;
          PX_PUPIL: rgb_d[i] = mode_pupil_c;
          default:  rgb_d[i] = TRANSPARENT;
        endcase
      end
    end
  end

  // Pixel output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        rgb_q[i] <= TRANSPARENT;
      end
      hit_q <= '0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= hit_d;
    end
  end

  always_comb begin
    drawingRequest = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      drawingRequest[i] = (rgb_q[i] != TRANSPARENT);
    end
  end

  assign RGBout      = rgb_q;
  assign hitEdgeCode = hit_q;
  assign mode        = state_q;
  assign legFrame    = leg_q;

endmodule

// File: doc/sprite_bank_animator.md
# sprite_bank_animator

Parametrised multi-channel ghost sprite renderer for the VGA path. It serves NUM_CH independent monster channels from one shared two-frame ghost bitmap. Per pixel it produces a registered RGB, a drawing request and an edge-hit code for every channel. It also owns the frame-based animation state: leg-frame toggling and a NORMAL/FRIGHT/BLINK mode machine. It sits between the per-monster square/offset generators and the object-priority mux.

## Interface
Parameters:
- NUM_CH, 3: number of monster channels.
- SIZE_BITS, 5: sprite is 2^SIZE_BITS square; must be ≥ 2.
- TRANSPARENT, 8'h00: RGB code meaning "do not draw".
- FRIGHT_COLOR, 8'h03: body colour in FRIGHT and in BLINK phase 0.
- BLINK_COLOR, 8'hFF: body colour in BLINK phase 1.
- FRIGHT_FRAMES, 360: frames spent in FRIGHT.
- BLINK_FRAMES, 120: frames spent in BLINK.
- BLINK_PERIOD, 15: frames per blink phase.
- ANIM_FRAMES, 8: frames per leg-frame toggle.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- frightenStart  in  1  one-cycle request to enter FRIGHT.
- offsetX  in  [NUM_CH][10:0]  pixel X offset from each sprite's top-left corner.
- offsetY  in  [NUM_CH][10:0]  pixel Y offset from each sprite's top-left corner.
- insideRect  in  [NUM_CH-1:0]  pixel lies inside that channel's bracket.
- chColor  in  [NUM_CH][7:0]  per-channel body colour used in NORMAL mode.
- RGBout  out  [NUM_CH][7:0]  registered pixel colour.
- drawingRequest  out  [NUM_CH-1:0]  high when RGBout ≠ TRANSPARENT.
- hitEdgeCode  out  [NUM_CH][3:0]  {Left,Top,Right,Bottom}, registered.
- mode  out  2  00 NORMAL, 01 FRIGHT, 10 BLINK.
- legFrame  out  1  current leg frame.

## Operation
- Bitmap ROM holds two frames, A and B, which differ only in the bottom rows (legs).
  - Pixel codes: FF body, FE eye white, 06 pupil, 00 transparent.
  - ROM is indexed [legFrame][offsetY][offsetX] with SIZE_BITS bits per axis.
- Colour map, per channel, applied only when insideRect[i]=1 and both offsets < 2^SIZE_BITS:
  - NORMAL: FF → chColor[i]. If chColor[i]==TRANSPARENT, use 8'h01 instead, so the body never disappears. FE and 06 pass through unchanged.
  - FRIGHT: FF → FRIGHT_COLOR; 06 → 8'hC0 (red pupils); FE unchanged.
  - BLINK: FF → FRIGHT_COLOR when blinkPhase=0, BLINK_COLOR when blinkPhase=1; 06 → 8'hC0.
  - Code 00 always stays TRANSPARENT.
  - Outside the bracket or out of range: RGBout=TRANSPARENT and hitEdgeCode=0.
- Hit code, indexed by the region grid row = offsetY[SIZE_BITS-1:SIZE_BITS-2], col = offsetX[SIZE_BITS-1:SIZE_BITS-2]:
  - row0: C,4,4,6
  - row1: 8,C,6,2
  - row2: 8,9,3,2
  - row3: 9,1,1,3
- Mode FSM. State, counters and legFrame change only in the cycle where startOfFrame=1, so there is no mid-frame tearing.
  - pendingFright is set by frightenStart in any cycle. It is cleared when consumed at startOfFrame.
  - If frightenStart and startOfFrame coincide, the request is consumed in that same cycle.
  - At SOF, pending (any state) → FRIGHT, frameCnt=0, blinkCnt=0, blinkPhase=0. Pending has priority over every other transition.
  - At SOF, FRIGHT with frameCnt==FRIGHT_FRAMES-1 → BLINK, frameCnt=0. Otherwise frameCnt+1.
  - At SOF, BLINK with frameCnt==BLINK_FRAMES-1 → NORMAL. Otherwise frameCnt+1.
    - In BLINK, blinkCnt counts up; at BLINK_PERIOD-1 it wraps to 0 and blinkPhase toggles.
  - NORMAL holds without pending.
- Animation: animCnt is free-running on SOF. At ANIM_FRAMES-1 it wraps to 0 and legFrame toggles. It is unaffected by mode.
- Counter widths are $clog2 of their limits and never overflow.

## Timing
- Reset (asynchronous, resetN=0) values:
  - RGBout all TRANSPARENT, drawingRequest 0, hitEdgeCode 0.
  - mode=NORMAL, legFrame=0 (frame A).
  - All counters 0, pendingFright=0, blinkPhase=0.
- Reset mid-frame or mid-FRIGHT returns to NORMAL immediately. A pending request is lost.
- Pixel path latency is 1 clk: inputs at edge N produce RGBout and hitEdgeCode after edge N+1.
  - drawingRequest is combinational from the registered RGBout (same cycle as RGBout).
- New mode and legFrame are visible from the cycle after the SOF edge. Pixels of that cycle use the new values.
- Channels are fully independent and concurrent; there is no arbitration between them.

## Test plan
Bench setup: NUM_CH=3, FRIGHT_FRAMES=4, BLINK_FRAMES=4, BLINK_PERIOD=2, ANIM_FRAMES=2.

1. Reset and basic pixels.
   - Stimulus: hold resetN=0, then release; chColor={F8,E0,0F}; all channels inside at offset (16,5).
   - Required: during reset, all outputs are 0. One clk after the offset is applied, RGBout={F8,E0,0F}, drawingRequest=3'b111.
2. Colour mapping, transparency and hit codes.
   - Pupil at (14,13): RGBout=06 in NORMAL.
   - Offset (0,0): RGBout=00, drawingRequest=0, hitEdgeCode=C.
   - insideRect=0: hitEdgeCode=0.
   - Offset X=40 while inside: RGBout=00.
   - chColor=00: body pixel gives RGBout=01.
3. Fright timeline.
   - Stimulus: frightenStart pulse, then SOF pulses.
   - Required: mode=01 after SOF1; body=03 and pupil=C0. After SOF5, mode=10.
   - Required in BLINK: body is 03,03,FF,FF on successive frames. After SOF9, mode=00.
4. Mid-fright re-trigger.
   - Stimulus: frightenStart while in BLINK at frameCnt=2.
   - Required: the next SOF gives mode=01, frameCnt=0, and BLINK starts 4 frames later.
   - Stimulus: frightenStart in the same cycle as an SOF.
   - Required: FRIGHT is entered on that SOF.
5. Leg animation.
   - Stimulus: sample a leg-row pixel that differs between frames A and B over 4 SOFs.
   - Required: legFrame reads 0,1,1,0,0 across the SOFs and the sampled pixel follows the frame. The frame holds steady between SOFs.
6. Reset during FRIGHT.
   - Stimulus: assert resetN=0 for 1 cycle while mode=01.
   - Required: mode=00 and RGBout=00 immediately; subsequent SOFs without a request stay in NORMAL.
